fifo_ctrl_d1: RTL and testbench



---
 rtl/fifo_ctrl_d1.sv | 111 +++++++++++
 tb/tb_fifo_ctrl_d1.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_d1.sv
// Synchronous FIFO: RAM, pointers, occupancy count, status and error flags.
// Define FIFO_ERR_STICKY_EN to hold overflow/underflow errors until reset.
module fifo_ctrl_d1 #(
  parameter int DATA_SIZE       = 10,
  parameter int ADDR_SIZE       = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 pop,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic [ADDR_SIZE:0]   fifo_count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow_err,
  output logic                 underflow_err
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_C = DEPTH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] AF_TH = ALMOST_FULL_TH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] AE_TH = ALMOST_EMPTY_TH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE:0] CNT_ONE = (ADDR_SIZE + 1)'(1);

  logic [DATA_SIZE-1:0] ram_q [DEPTH];

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;

  logic push_ok, pop_ok, ovf_ev, udf_ev;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign ovf_ev  = push & ~push_ok;
  assign udf_ev  = pop & ~pop_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      data_d   = ram_q[rd_ptr_q];
      valid_d  = 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
`ifdef FIFO_ERR_STICKY_EN
    ovf_d = ovf_q | ovf_ev;
    udf_d = udf_q | udf_ev;
`else
    ovf_d = ovf_ev;
    udf_d = udf_ev;
`endif
  end

  // Storage is not reset; a full-with-pop read sees the old word.
  always_ff @(posedge clk) begin
    if (push_ok) ram_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign fifo_count    = count_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;

endmodule

// File: tb/tb_fifo_ctrl_d1.sv
// Scoreboard bench for fifo_ctrl_d1: queue reference model, popped-data monitor.
// Honours FIFO_ERR_STICKY_EN in the model.
module tb_fifo_ctrl_d1;

  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          push, pop;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [AW:0]   fifo_count;
  logic          full, empty, almost_full, almost_empty;
  logic          overflow_err, underflow_err;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_data[$];
  bit            m_ovf, m_udf;

  fifo_ctrl_d1 dut (
    .clk(clk), .reset_L(reset_L),
    .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .data_valid(data_valid),
    .fifo_count(fifo_count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every popped word must match the scoreboard head.
  always @(negedge clk) begin
    if (reset_L && data_valid) begin
      checks++;
      if (exp_data.size() == 0) begin
        errors++;
        $display("FAIL data_spurious: got %0h expected none", data_out);
      end else begin
        logic [DW-1:0] e;
        e = exp_data.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL data_out: got %0h expected %0h", data_out, e);
        end
      end
    end
  end

  task automatic check_status(string tag, bit exp_valid);
    int n;
    n = model_q.size();
    chk({tag, ".count"}, int'(fifo_count), n);
    chk({tag, ".full"}, int'(full), int'(n == DEPTH));
    chk({tag, ".empty"}, int'(empty), int'(n == 0));
    chk({tag, ".afull"}, int'(almost_full), int'(n >= AF));
    chk({tag, ".aempty"}, int'(almost_empty), int'(n <= AE));
    chk({tag, ".valid"}, int'(data_valid), int'(exp_valid));
    chk({tag, ".ovf"}, int'(overflow_err), int'(m_ovf));
    chk({tag, ".udf"}, int'(underflow_err), int'(m_udf));
  endtask

  // One clock of stimulus; called #1 after a rising edge.
  task automatic step(bit p, bit r, logic [DW-1:0] d);
    bit pop_ok, push_ok;
    push = p; pop = r; data_in = d;
    pop_ok  = r && (model_q.size() > 0);
    push_ok = p && (model_q.size() < DEPTH || pop_ok);
    if (pop_ok) exp_data.push_back(model_q.pop_front());
    if (push_ok) model_q.push_back(d);
`ifdef FIFO_ERR_STICKY_EN
    m_ovf = m_ovf | (p && !push_ok);
    m_udf = m_udf | (r && !pop_ok);
`else
    m_ovf = p && !push_ok;
    m_udf = r && !pop_ok;
`endif
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
    check_status("step", pop_ok);
  endtask

  task automatic check_reset(string tag);
    chk({tag, ".count"}, int'(fifo_count), 0);
    chk({tag, ".empty"}, int'(empty), 1);
    chk({tag, ".full"}, int'(full), 0);
    chk({tag, ".aempty"}, int'(almost_empty), 1);
    chk({tag, ".afull"}, int'(almost_full), 0);
    chk({tag, ".valid"}, int'(data_valid), 0);
    chk({tag, ".dout"}, int'(data_out), 0);
    chk({tag, ".ovf"}, int'(overflow_err), 0);
    chk({tag, ".udf"}, int'(underflow_err), 0);
  endtask

  task automatic do_reset();
    #2 reset_L = 1'b0;
    #1;
    model_q.delete();
    exp_data.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_reset("rst");
    @(posedge clk);
    @(posedge clk);
    #1 reset_L = 1'b1;
  endtask

  initial begin
    reset_L = 1'b0;
    push = 1'b0; pop = 1'b0; data_in = '0;
    m_ovf = 1'b0; m_udf = 1'b0;
    #1 check_reset("por");
    @(posedge clk);
    @(posedge clk);
    #1 reset_L = 1'b1;

    for (int i = 1; i <= 8; i++) step(1, 0, DW'(i));
    step(1, 0, 10'h3FF);
    for (int i = 0; i < 8; i++) step(0, 1, '0);
    step(0, 0, '0);

    for (int i = 0; i < 5; i++) step(1, 0, DW'($urandom_range(0, 1023)));
    for (int i = 0; i < 5; i++) step(0, 1, '0);
    for (int i = 0; i < 5; i++) step(1, 0, DW'(10 + i));
    for (int i = 0; i < 5; i++) step(0, 1, '0);

    for (int i = 0; i < 8; i++) step(1, 0, DW'(32 + i));
    step(1, 1, 10'h155);
    for (int i = 0; i < 8; i++) step(0, 1, '0);

    step(1, 1, 10'h0AA);
    step(0, 1, '0);
    step(0, 0, '0);

    for (int i = 0; i < 8; i++) step(1, 0, DW'(64 + i));
    step(1, 0, 10'h2AA);
    for (int i = 0; i < 4; i++) step(0, 1, '0);
    chk("pre_rst.count", int'(fifo_count), 4);
    do_reset();

    step(1, 0, 10'h1C3);
    step(0, 1, '0);
    step(0, 0, '0);

    for (int i = 0; i < 400; i++) begin
      bit p, r;
      p = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
      r = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
      step(p, r, DW'($urandom_range(0, 1023)));
    end

    for (int i = 0; i < DEPTH + 1; i++) step(0, 1, '0);
    step(0, 0, '0);
    step(0, 0, '0);
    chk("drain.sb_left", exp_data.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
